// File: rtl/lzrw_pkg.sv
// Shared constants and types for the LZRW1 hash-table-of-pointers.
// Default table geometry, the table entry layout and the sweep/run state encoding.
package lzrw_pkg;

   localparam int unsigned LZRW_HASH_W   = 12;
   localparam int unsigned LZRW_POS_W    = 32;
   localparam int unsigned LZRW_OFFSET_W = 12;

   typedef struct packed {
      logic                  valid;
      logic [LZRW_POS_W-1:0] pos;
   } ht_entry_t;

   localparam int unsigned LZRW_ENTRY_W = $bits(ht_entry_t);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } ht_state_e;

endpackage

// File: rtl/lzrw_ht_mem.sv
// DEPTH x ht_entry_t pointer storage: one synchronous write port, one combinational read port.
// A read and a write to the same address in one cycle return the old contents.
module lzrw_ht_mem
   import lzrw_pkg::*;
#(
   parameter int unsigned HASH_W = LZRW_HASH_W
) (
   input  logic                    clock,
   input  logic                    writeEn,
   input  logic [HASH_W-1:0]       writeAddr,
   input  logic [LZRW_ENTRY_W-1:0] writeData,
   input  logic [HASH_W-1:0]       readAddr,
   output logic [LZRW_ENTRY_W-1:0] readData
);

   localparam int unsigned DEPTH = 2 ** HASH_W;

   // No reset on the array: the owner sweeps it clear through the write port.
   ht_entry_t store [DEPTH];

   always_ff @(posedge clock) begin
      if (writeEn) begin
         store[writeAddr] <= ht_entry_t'(writeData);
      end
   end

   assign readData = store[readAddr];

endmodule

// File: rtl/lzrw_hash_table.sv
// LZRW1 hash table of pointers with valid bits, valid/ready handshake, sweep clear and window check.
// Optional macro LZRW_HT_STATS_EN adds saturating lookup/hit counters (stat_lookups, stat_hits).
module lzrw_hash_table
   import lzrw_pkg::*;
#(
   parameter int unsigned HASH_W   = LZRW_HASH_W,
   parameter int unsigned POS_W    = LZRW_POS_W,
   parameter int unsigned OFFSET_W = LZRW_OFFSET_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   output logic                busy,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [HASH_W-1:0]   in_hash,
   input  logic [POS_W-1:0]    in_pos,
   input  logic [7:0]          in_byte,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_hit,
   output logic [POS_W-1:0]    out_old_pos,
   output logic [OFFSET_W-1:0] out_offset,
   output logic [7:0]          out_byte
`ifdef LZRW_HT_STATS_EN
   ,
   output logic [31:0]         stat_lookups,
   output logic [31:0]         stat_hits
`endif
);

   localparam int unsigned      DEPTH      = 2 ** HASH_W;
   localparam logic [HASH_W-1:0] LAST_IDX  = HASH_W'(DEPTH - 1);
   localparam logic [POS_W-1:0]  MAX_OFFSET = POS_W'(2 ** OFFSET_W - 1);

   ht_state_e                state;
   logic [HASH_W-1:0]        sweepIdx;

   logic                     accept;
   logic                     memWe;
   logic [HASH_W-1:0]        memAddr;
   ht_entry_t                wrEntry;
   ht_entry_t                rdEntry;
   logic [LZRW_ENTRY_W-1:0]  rdBits;
   logic [POS_W-1:0]         oldPos;
   logic [POS_W-1:0]         diff;
   logic                     hitC;

   lzrw_ht_mem #(
      .HASH_W (HASH_W)
   ) u_mem (
      .clock     (clock),
      .writeEn   (memWe),
      .writeAddr (memAddr),
      .writeData (wrEntry),
      .readAddr  (in_hash),
      .readData  (rdBits)
   );

   assign rdEntry = ht_entry_t'(rdBits);
   assign busy    = (state == CLEAR);

   // Handshake, table write steering and hit evaluation on the pre-write entry.
   always_comb begin
      in_ready = (state == RUN) && !clear && (!out_valid || out_ready);
      accept   = in_valid && in_ready;

      memWe         = (state == CLEAR) || accept;
      memAddr       = (state == CLEAR) ? sweepIdx : in_hash;
      wrEntry.valid = (state == RUN);
      wrEntry.pos   = (state == RUN) ? LZRW_POS_W'(in_pos) : '0;

      oldPos = rdEntry.valid ? POS_W'(rdEntry.pos) : '0;
      diff   = in_pos - oldPos;
      hitC   = rdEntry.valid && (diff != '0) && (diff <= MAX_OFFSET);
   end

   // Sweep/run FSM plus the result register; a pending result survives a clear request.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= CLEAR;
         sweepIdx    <= '0;
         out_valid   <= 1'b0;
         out_hit     <= 1'b0;
         out_old_pos <= '0;
         out_offset  <= '0;
         out_byte    <= '0;
      end else begin
         case (state)
            CLEAR: begin
               sweepIdx <= sweepIdx + HASH_W'(1);
               if (sweepIdx == LAST_IDX) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (clear) begin
                  state    <= CLEAR;
                  sweepIdx <= '0;
               end
            end
            default: state <= CLEAR;
         endcase

         if (accept) begin
            out_valid   <= 1'b1;
            out_hit     <= hitC;
            out_old_pos <= oldPos;
            out_offset  <= hitC ? diff[OFFSET_W-1:0] : '0;
            out_byte    <= hitC ? 8'h00 : in_byte;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef LZRW_HT_STATS_EN
   logic resultTaken;
   assign resultTaken = out_valid && out_ready;

   // Saturating counters on result handshake; zeroed by reset and on entry to the sweep.
   always_ff @(posedge clock) begin
      if (!reset || (state == RUN && clear)) begin
         stat_lookups <= '0;
         stat_hits    <= '0;
      end else if (resultTaken) begin
         if (stat_lookups != '1) begin
            stat_lookups <= stat_lookups + 32'd1;
         end
         if (out_hit && (stat_hits != '1)) begin
            stat_hits <= stat_hits + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lzrw_hash_table.sv
// Directed, table-driven bench for lzrw_hash_table (default geometry 4096 x 32-bit positions).
// Stats counters are exercised only when LZRW_HT_STATS_EN is defined.
module tb_lzrw_hash_table;

   localparam int unsigned HASH_W   = 12;
   localparam int unsigned POS_W    = 32;
   localparam int unsigned OFFSET_W = 12;
   localparam int unsigned DEPTH    = 4096;

   logic                clock     = 1'b0;
   logic                reset     = 1'b0;
   logic                clear     = 1'b0;
   logic                busy;
   logic                in_valid  = 1'b0;
   logic                in_ready;
   logic [HASH_W-1:0]   in_hash   = '0;
   logic [POS_W-1:0]    in_pos    = '0;
   logic [7:0]          in_byte   = '0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic                out_hit;
   logic [POS_W-1:0]    out_old_pos;
   logic [OFFSET_W-1:0] out_offset;
   logic [7:0]          out_byte;
`ifdef LZRW_HT_STATS_EN
   logic [31:0]         stat_lookups;
   logic [31:0]         stat_hits;
`endif

   lzrw_hash_table dut (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear),
      .busy        (busy),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_hash     (in_hash),
      .in_pos      (in_pos),
      .in_byte     (in_byte),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_hit     (out_hit),
      .out_old_pos (out_old_pos),
      .out_offset  (out_offset),
      .out_byte    (out_byte)
`ifdef LZRW_HT_STATS_EN
      ,
      .stat_lookups (stat_lookups),
      .stat_hits    (stat_hits)
`endif
   );

   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [HASH_W-1:0]   hash;
      logic [POS_W-1:0]    pos;
      logic [7:0]          dataByte;
      logic                hit;
      logic [POS_W-1:0]    oldPos;
      logic [OFFSET_W-1:0] offset;
      logic [7:0]          outByte;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one request with out_ready as currently driven; returns #1 after the accept edge.
   task automatic doLookup(input logic [HASH_W-1:0] hash, input logic [POS_W-1:0] pos,
                           input logic [7:0] dataByte);
      int n;
      in_valid = 1'b1;
      in_hash  = hash;
      in_pos   = pos;
      in_byte  = dataByte;
      #1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      check("accept_ready", in_ready, 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   // Count edges until busy drops, bounded; entered #1 after the edge that started the sweep.
   task automatic waitSweep(input string name);
      int n;
      n = 0;
      while (busy && n < DEPTH + 100) begin
         if (n == DEPTH / 2) check({name, "_ready_low"}, in_ready, 0);
         @(posedge clock); #1;
         n++;
      end
      check({name, "_len"}, n, DEPTH);
      check({name, "_ready_after"}, in_ready, 1);
   endtask

   task automatic checkResult(input string name, input logic hit, input logic [POS_W-1:0] oldPos,
                              input logic [OFFSET_W-1:0] offset, input logic [7:0] outByte);
      check({name, "_valid"},  out_valid,   1);
      check({name, "_hit"},    out_hit,     hit);
      check({name, "_oldpos"}, out_old_pos, oldPos);
      check({name, "_offset"}, out_offset,  offset);
      check({name, "_byte"},   out_byte,    outByte);
   endtask

   initial begin
      vecs[0]  = '{12'h005, 32'd10,         8'h41, 1'b0, 32'd0,          12'd0,    8'h41};
      vecs[1]  = '{12'h005, 32'd20,         8'h42, 1'b1, 32'd10,         12'd10,   8'h00};
      vecs[2]  = '{12'h123, 32'd100,        8'h10, 1'b0, 32'd0,          12'd0,    8'h10};
      vecs[3]  = '{12'h123, 32'd4196,       8'h11, 1'b0, 32'd100,        12'd0,    8'h11};
      vecs[4]  = '{12'h123, 32'd4200,       8'h12, 1'b1, 32'd4196,       12'd4,    8'h00};
      vecs[5]  = '{12'h123, 32'd4200,       8'h13, 1'b0, 32'd4200,       12'd0,    8'h13};
      vecs[6]  = '{12'h7FF, 32'hFFFF_FFFE,  8'h20, 1'b0, 32'd0,          12'd0,    8'h20};
      vecs[7]  = '{12'h7FF, 32'h0000_0001,  8'h21, 1'b1, 32'hFFFF_FFFE,  12'd3,    8'h00};
      vecs[8]  = '{12'hFFF, 32'd0,          8'h30, 1'b0, 32'd0,          12'd0,    8'h30};
      vecs[9]  = '{12'hFFF, 32'd4095,       8'h31, 1'b1, 32'd0,          12'd4095, 8'h00};
      vecs[10] = '{12'h000, 32'd50,         8'h40, 1'b0, 32'd0,          12'd0,    8'h40};
      vecs[11] = '{12'h005, 32'd30,         8'h43, 1'b1, 32'd20,         12'd10,   8'h00};

      // Reset state.
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy",      busy,        1);
      check("rst_in_ready",  in_ready,    0);
      check("rst_out_valid", out_valid,   0);
      check("rst_hit",       out_hit,     0);
      check("rst_oldpos",    out_old_pos, 0);
      check("rst_offset",    out_offset,  0);
      check("rst_byte",      out_byte,    0);
      reset = 1'b1;
      waitSweep("rst_sweep");

      // Table-driven lookups, back to back with out_ready high.
      for (int i = 0; i < 12; i++) begin
         doLookup(vecs[i].hash, vecs[i].pos, vecs[i].dataByte);
         checkResult($sformatf("vec%0d", i), vecs[i].hit, vecs[i].oldPos, vecs[i].offset,
                     vecs[i].outByte);
      end
      @(posedge clock); #1;
      check("drain_valid", out_valid, 0);

      // Consecutive accepts to one hash: second sees the first one's write.
      in_valid = 1'b1; in_hash = 12'h0AA; in_pos = 32'd500; in_byte = 8'h55;
      #1;
      check("b2b_ready0", in_ready, 1);
      @(posedge clock); #1;
      checkResult("b2b_first", 1'b0, 32'd0, 12'd0, 8'h55);
      in_pos = 32'd503; in_byte = 8'h56;
      #1;
      check("b2b_ready1", in_ready, 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      checkResult("b2b_second", 1'b1, 32'd500, 12'd3, 8'h00);
      @(posedge clock); #1;

      // Backpressure: result held stable, no new accept while out_ready is low.
      out_ready = 1'b0;
      in_valid = 1'b1; in_hash = 12'h0BB; in_pos = 32'd600; in_byte = 8'h66;
      @(posedge clock); #1;
      in_pos = 32'd610; in_byte = 8'h67;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("hold_ready", in_ready, 0);
         checkResult("hold", 1'b0, 32'd0, 12'd0, 8'h66);
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      #1;
      check("release_ready", in_ready, 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      checkResult("release_next", 1'b1, 32'd600, 12'd10, 8'h00);

      // Clear after three lookups, then the same hashes all miss.
      doLookup(12'h005, 32'd40,   8'h01);
      doLookup(12'h123, 32'd4300, 8'h02);
      doLookup(12'hFFF, 32'd5000, 8'h03);
      clear = 1'b1;
      #1;
      check("clear_req_ready", in_ready, 0);
      @(posedge clock); #1;
      clear = 1'b0;
      check("clear_busy", busy, 1);
      check("clear_pending_taken", out_valid, 0);
      waitSweep("clear_sweep");
`ifdef LZRW_HT_STATS_EN
      check("stat_lookups_after_clear", stat_lookups, 0);
      check("stat_hits_after_clear",    stat_hits,    0);
`endif
      doLookup(12'h005, 32'd90, 8'hA0);
      checkResult("post_clear_005", 1'b0, 32'd0, 12'd0, 8'hA0);
      doLookup(12'h123, 32'd91, 8'hA1);
      checkResult("post_clear_123", 1'b0, 32'd0, 12'd0, 8'hA1);
      doLookup(12'hFFF, 32'd92, 8'hA2);
      checkResult("post_clear_fff", 1'b0, 32'd0, 12'd0, 8'hA2);
      @(posedge clock); #1;

`ifdef LZRW_HT_STATS_EN
      // Stats: 10 lookups with 4 repeats inside the window.
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      waitSweep("stats_sweep");
      for (int i = 0; i < 10; i++) begin
         doLookup(12'h300 + 12'(i % 6), 32'd1000 + 32'(i), 8'(i));
      end
      @(posedge clock); #1;
      check("stat_lookups", stat_lookups, 32'd10);
      check("stat_hits",    stat_hits,    32'd4);
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      check("stat_lookups_cleared", stat_lookups, 0);
      check("stat_hits_cleared",    stat_hits,    0);
      waitSweep("stats_sweep2");
`endif

      // Reset mid-operation discards the pending result and re-sweeps.
      out_ready = 1'b0;
      doLookup(12'h005, 32'd70, 8'hB0);
      check("midrst_pending", out_valid, 1);
      reset = 1'b0;
      @(posedge clock); #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_busy",  busy,      1);
      check("midrst_hit",   out_hit,   0);
      reset = 1'b1;
      waitSweep("midrst_sweep");
      out_ready = 1'b1;
      doLookup(12'h005, 32'd80, 8'hB1);
      checkResult("midrst_lookup", 1'b0, 32'd0, 12'd0, 8'hB1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
